ternary_neuron_acc: RTL and testbench

Sequential accumulate-and-threshold stage that sits directly downstream of a pair of 8-input popcount units in the printed ternary-neuron datapath. Each beat carries the popcount of the +1-weighted inputs (`pos_pc`) and the popcount of the −1-weighted inputs (`neg_pc`) for one 8-input chunk. The block accumulates `pos_pc − neg_pc` over a frame of chunks with saturation, then applies two thresholds to produce a ternary activation. It has a valid/ready handshake on both sides.

---
 rtl/tnn_pkg.sv | 33 +++
 rtl/tnn_sat_acc.sv | 36 +++
 rtl/ternary_neuron_acc.sv | 103 ++++++++++
 tb/tb_ternary_neuron_acc.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared types, activation encodings and saturating arithmetic for the
// ternary-neuron datapath.
package tnn_pkg;

    typedef enum logic [1:0] {IDLE, ACC, EMIT} acc_state_t;

    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_ZERO = 2'b00;
    localparam logic [1:0] ACT_NEG  = 2'b11;

    // Chunk delta width: pos_pc - neg_pc spans -15..+15.
    localparam int DELTA_W = 5;

    // Adds two sign-extended operands at full width, then clamps the sum to
    // the signed range of a w-bit accumulator (w <= 32). The caller narrows
    // the result to w bits.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [32:0] sum;
        logic signed [32:0] max_v;
        logic signed [32:0] min_v;
        sum   = 33'(a) + 33'(b);
        max_v = (33'sd1 <<< (w - 1)) - 33'sd1;
        min_v = -(33'sd1 <<< (w - 1));
        if (sum > max_v)
            sum = max_v;
        else if (sum < min_v)
            sum = min_v;
        return 32'(sum);
    endfunction

endpackage

// File: rtl/tnn_sat_acc.sv
// Registered saturating accumulator. 'load' starts a new sum from the
// incoming delta, 'add' accumulates into the current value. The next value
// is also exposed so the parent can act on the final sum on the same edge.
module tnn_sat_acc
    import tnn_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      add,
    input  logic signed [DELTA_W-1:0] d,
    output logic signed [ACC_W-1:0]   acc,
    output logic signed [ACC_W-1:0]   acc_next
);

    logic signed [31:0] base;

    // Next accumulator value: loading restarts from zero so nothing stale survives.
    always_comb begin
        base     = load ? 32'sd0 : 32'(acc);
        acc_next = acc;
        if (load || add)
            acc_next = ACC_W'(sat_add(base, 32'(d), ACC_W));
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else
            acc <= acc_next;
    end

endmodule

// File: rtl/ternary_neuron_acc.sv
// Accumulate-and-threshold stage: sums (pos_pc - neg_pc) over a frame of
// chunks with saturation, then emits a ternary activation.
module ternary_neuron_acc
    import tnn_pkg::*;
#(
    parameter int ACC_W  = 8,
    parameter int THR_HI = 2,
    parameter int THR_LO = -2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       pos_pc,
    input  logic [3:0]       neg_pc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_act,
    output logic [ACC_W-1:0] out_acc
);

    if (THR_LO > THR_HI) begin : g_thr_order_check
        $error("ternary_neuron_acc: THR_LO must not exceed THR_HI");
    end
    if (ACC_W < 6 || ACC_W > 31) begin : g_acc_w_check
        $error("ternary_neuron_acc: ACC_W must be in 6..31");
    end

    localparam logic signed [ACC_W:0] THR_HI_W = (ACC_W + 1)'(THR_HI);
    localparam logic signed [ACC_W:0] THR_LO_W = (ACC_W + 1)'(THR_LO);

    acc_state_t                state;
    logic                      accept;
    logic                      load;
    logic                      add;
    logic signed [DELTA_W-1:0] delta;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W:0]     acc_cmp;
    logic [1:0]                act_next;

    assign in_ready = (state != EMIT);
    assign accept   = in_valid && in_ready;
    assign load     = accept && (state == IDLE);
    assign add      = accept && (state == ACC);
    assign delta    = $signed({1'b0, pos_pc}) - $signed({1'b0, neg_pc});

    tnn_sat_acc #(
        .ACC_W(ACC_W)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .add     (add),
        .d       (delta),
        .acc     (acc),
        .acc_next(acc_next)
    );

    // Threshold decision on the value the accumulator takes at this edge.
    always_comb begin
        acc_cmp  = (ACC_W + 1)'(acc_next);
        act_next = ACT_ZERO;
        if (acc_cmp > THR_HI_W)
            act_next = ACT_POS;
        else if (acc_cmp < THR_LO_W)
            act_next = ACT_NEG;
    end

    // Frame FSM with registered activation outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_act   <= ACT_ZERO;
            out_acc   <= '0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        if (in_last) begin
                            state     <= EMIT;
                            out_valid <= 1'b1;
                            out_act   <= act_next;
                            out_acc   <= acc_next;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Directed, table-driven bench. Two instances (ACC_W=8 and ACC_W=6) see the
// same stimulus; each is checked against hand-computed expectations.
module tb_ternary_neuron_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] pos_pc;
    logic [3:0] neg_pc;
    logic       in_last;
    logic       out_ready;

    logic       in_ready8, out_valid8, in_ready6, out_valid6;
    logic [1:0] out_act8, out_act6;
    logic [7:0] out_acc8;
    logic [5:0] out_acc6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ternary_neuron_acc #(.ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .pos_pc(pos_pc), .neg_pc(neg_pc), .in_last(in_last),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_act(out_act8), .out_acc(out_acc8)
    );

    ternary_neuron_acc #(.ACC_W(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6),
        .pos_pc(pos_pc), .neg_pc(neg_pc), .in_last(in_last),
        .out_valid(out_valid6), .out_ready(out_ready),
        .out_act(out_act6), .out_acc(out_acc6)
    );

    typedef struct {
        string       name;
        int          n;
        logic [15:0] pos;   // nibble i = chunk i
        logic [15:0] neg;
        int          exp8;
        int          exp6;
        logic [1:0]  act8;
        logic [1:0]  act6;
    } frame_t;

    frame_t tbl[10];

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one chunk and wait (bounded) until it is accepted.
    task automatic apply_chunk(input logic [3:0] p, input logic [3:0] n, input logic last);
        int k;
        in_valid = 1'b1;
        pos_pc   = p;
        neg_pc   = n;
        in_last  = last;
        for (k = 0; k < 20 && !in_ready8; k++) tick();
        chk("in_ready_wait", int'(in_ready8), 1);
        tick();
    endtask

    task automatic check_emit(input string name, input int e8, input int e6,
                              input logic [1:0] a8, input logic [1:0] a6);
        chk({name, "_valid8"}, int'(out_valid8), 1);
        chk({name, "_valid6"}, int'(out_valid6), 1);
        chk({name, "_acc8"}, int'($signed(out_acc8)), e8);
        chk({name, "_acc6"}, int'($signed(out_acc6)), e6);
        chk({name, "_act8"}, int'(out_act8), int'(a8));
        chk({name, "_act6"}, int'(out_act6), int'(a6));
        chk({name, "_in_ready"}, int'(in_ready8), 0);
    endtask

    task automatic run_frame(input frame_t f);
        for (int i = 0; i < f.n; i++)
            apply_chunk(f.pos[i*4 +: 4], f.neg[i*4 +: 4], (i == f.n - 1));
        in_valid = 1'b0;
        check_emit(f.name, f.exp8, f.exp6, f.act8, f.act6);
        $display("frame %s: acc8=%0d acc6=%0d act8=%b act6=%b", f.name,
                 $signed(out_acc8), $signed(out_acc6), out_act8, out_act6);
        tick();
        chk({f.name, "_done"}, int'(out_valid8), 0);
    endtask

    // Back-to-back scoreboard data: four 2-chunk frames.
    logic [3:0] bb_pos[8] = '{4'd4, 4'd3, 4'd0, 4'd1, 4'd2, 4'd1, 4'd7, 4'd0};
    logic [3:0] bb_neg[8] = '{4'd1, 4'd0, 4'd5, 4'd2, 4'd2, 4'd0, 4'd0, 4'd4};
    int         bb_exp[4] = '{6, -6, 1, 3};
    logic [1:0] bb_act[4] = '{2'b01, 2'b11, 2'b00, 2'b01};

    initial begin
        logic [1:0] held_act;
        logic [7:0] held_acc;
        int idx, got, last_cyc;
        logic accept;

        tbl[0] = '{"single",   1, 16'h0005, 16'h0001,   4,   4, 2'b01, 2'b01};
        tbl[1] = '{"lo_bound", 3, 16'h0123, 16'h0143,  -2,  -2, 2'b00, 2'b00};
        tbl[2] = '{"below_lo", 3, 16'h0123, 16'h0243,  -3,  -3, 2'b11, 2'b11};
        tbl[3] = '{"hi_bound", 1, 16'h0002, 16'h0000,   2,   2, 2'b00, 2'b00};
        tbl[4] = '{"above_hi", 1, 16'h0003, 16'h0000,   3,   3, 2'b01, 2'b01};
        tbl[5] = '{"desat",    4, 16'h0FFF, 16'hF000,  30,  16, 2'b01, 2'b01};
        tbl[6] = '{"neg_sat",  3, 16'h0000, 16'h0FFF, -45, -32, 2'b11, 2'b11};
        tbl[7] = '{"cancel",   2, 16'h00F0, 16'h00F0,   0,   0, 2'b00, 2'b00};
        tbl[8] = '{"max_pos",  1, 16'h000F, 16'h0000,  15,  15, 2'b01, 2'b01};
        tbl[9] = '{"max_neg",  1, 16'h0000, 16'h000F, -15, -15, 2'b11, 2'b11};

        rst = 1'b1; in_valid = 1'b0; pos_pc = '0; neg_pc = '0;
        in_last = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_out_valid", int'(out_valid8), 0);
        chk("rst_in_ready", int'(in_ready8), 1);
        chk("rst_in_ready6", int'(in_ready6), 1);
        chk("rst_out_act", int'(out_act8), 0);
        chk("rst_out_acc", int'(out_acc8), 0);
        rst = 1'b0;
        tick();

        foreach (tbl[i]) run_frame(tbl[i]);

        // Twenty (15,0) chunks saturate both widths, then a one-chunk frame reloads.
        for (int i = 0; i < 20; i++) apply_chunk(4'd15, 4'd0, (i == 19));
        in_valid = 1'b0;
        check_emit("sat20", 127, 31, 2'b01, 2'b01);
        $display("frame sat20: acc8=%0d acc6=%0d", $signed(out_acc8), $signed(out_acc6));
        tick();
        run_frame(tbl[9]);

        // Downstream stall with the next frame waiting upstream.
        out_ready = 1'b0;
        apply_chunk(4'd5, 4'd1, 1'b1);
        pos_pc = 4'd2; neg_pc = 4'd0; in_last = 1'b1; in_valid = 1'b1;
        held_act = out_act8;
        held_acc = out_acc8;
        chk("stall_first_acc", int'(out_acc8), 4);
        for (int c = 0; c < 5; c++) begin
            chk("stall_in_ready", int'(in_ready8), 0);
            chk("stall_out_valid", int'(out_valid8), 1);
            chk("stall_act_hold", int'(out_act8), int'(held_act));
            chk("stall_acc_hold", int'(out_acc8), int'(held_acc));
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("release_valid_low", int'(out_valid8), 0);
        chk("release_in_ready", int'(in_ready8), 1);
        tick();
        in_valid = 1'b0;
        check_emit("after_stall", 2, 2, 2'b00, 2'b00);
        $display("frame after_stall: acc8=%0d act8=%b", $signed(out_acc8), out_act8);
        tick();
        chk("no_dup_1", int'(out_valid8), 0);
        tick();
        chk("no_dup_2", int'(out_valid8), 0);

        // Reset during the second chunk of a frame discards the partial sum.
        apply_chunk(4'd3, 4'd0, 1'b0);
        pos_pc = 4'd4; neg_pc = 4'd0; in_last = 1'b0; in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid8), 0);
        chk("midrst_in_ready", int'(in_ready8), 1);
        chk("midrst_out_acc", int'(out_acc8), 0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        apply_chunk(4'd6, 4'd0, 1'b1);
        in_valid = 1'b0;
        check_emit("post_rst", 6, 6, 2'b01, 2'b01);
        $display("frame post_rst: acc8=%0d", $signed(out_acc8));
        tick();

        // Back-to-back 2-chunk frames with in_valid held high.
        idx = 0; got = 0; last_cyc = -1;
        in_valid = 1'b1;
        pos_pc = bb_pos[0]; neg_pc = bb_neg[0]; in_last = 1'b0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            accept = in_ready8;
            tick();
            if (accept) idx++;
            if (out_valid8) begin
                chk("bb_acc", int'($signed(out_acc8)), bb_exp[got]);
                chk("bb_act", int'(out_act8), int'(bb_act[got]));
                if (last_cyc >= 0) chk("bb_spacing", c - last_cyc, 3);
                $display("bb frame %0d: acc8=%0d act8=%b cycle=%0d", got,
                         $signed(out_acc8), out_act8, c);
                last_cyc = c;
                got++;
            end
            if (idx < 8) begin
                pos_pc  = bb_pos[idx];
                neg_pc  = bb_neg[idx];
                in_last = idx[0];
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("bb_frames", got, 4);
        chk("bb_beats", idx, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
